// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory-port arbiter: controller op encoding,
// arbiter state and port-owner identifiers, plus small helpers.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      MEM_NOP   = 2'b00,
      MEM_READ  = 2'b01,
      MEM_WRITE = 2'b10
   } mem_ctrl_op_e;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'b00,
      ARB_BUSY    = 2'b01,
      ARB_RELEASE = 2'b10
   } arb_state_e;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_DBG = 1'b1
   } arb_owner_e;

   // Width of the watchdog counter; covers TIMEOUT_CYCLES up to 255.
   localparam int unsigned WD_WIDTH = 8;

   // A request is live only for READ or WRITE; the unused 2'b11 code counts as idle.
   function automatic logic op_active(input mem_ctrl_op_e op);
      case (op)
         MEM_READ, MEM_WRITE: return 1'b1;
         default:             return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// Transfer watchdog: counts busy cycles and flags when the limit is reached.
module mem_arb_watchdog
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [WD_WIDTH-1:0] LIMIT_C = WD_WIDTH'(TIMEOUT_CYCLES - 1);

   logic [WD_WIDTH-1:0] count_r;

   // Busy-cycle counter; saturates at the limit so it never wraps.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count_r <= {WD_WIDTH{1'b0}};
      end else if (clear) begin
         count_r <= {WD_WIDTH{1'b0}};
      end else if (enable && (count_r != LIMIT_C)) begin
         count_r <= count_r + {{(WD_WIDTH-1){1'b0}}, 1'b1};
      end else begin
         count_r <= count_r;
      end
   end

   assign expired = (count_r == LIMIT_C);

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (cpu, dbg) round-robin arbiter in front of the single
// memory-controller port, with debug hold and a transfer watchdog.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned DATA_BUS_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH     = 16,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                      clock,
   input  logic                      reset,
   input  mem_ctrl_op_e              cpu_op,
   input  logic [ADDR_WIDTH-1:0]     cpu_addr,
   input  logic [DATA_BUS_WIDTH-1:0] cpu_wdata,
   output logic [DATA_BUS_WIDTH-1:0] cpu_rdata,
   output logic                      cpu_done,
   input  mem_ctrl_op_e              dbg_op,
   input  logic [ADDR_WIDTH-1:0]     dbg_addr,
   input  logic [DATA_BUS_WIDTH-1:0] dbg_wdata,
   output logic [DATA_BUS_WIDTH-1:0] dbg_rdata,
   output logic                      dbg_done,
   input  logic                      dbg_hold,
   output mem_ctrl_op_e              mem_op,
   output logic [ADDR_WIDTH-1:0]     mem_addr,
   output logic [DATA_BUS_WIDTH-1:0] mem_wdata,
   input  logic [DATA_BUS_WIDTH-1:0] mem_rdata,
   input  logic                      mem_done,
   output logic                      owner_dbg,
   output logic                      timeout_err
);

   arb_state_e                state_r,      state_s;
   mem_ctrl_op_e              mem_op_r,     mem_op_s;
   logic [ADDR_WIDTH-1:0]     mem_addr_r,   mem_addr_s;
   logic [DATA_BUS_WIDTH-1:0] mem_wdata_r,  mem_wdata_s;
   logic [DATA_BUS_WIDTH-1:0] cpu_rdata_r,  cpu_rdata_s;
   logic [DATA_BUS_WIDTH-1:0] dbg_rdata_r,  dbg_rdata_s;
   logic                      cpu_done_r,   cpu_done_s;
   logic                      dbg_done_r,   dbg_done_s;
   arb_owner_e                owner_r,      owner_s;
   arb_owner_e                last_grant_r, last_grant_s;
   logic                      timeout_err_r, timeout_err_s;

   logic cpu_elig_s;
   logic dbg_elig_s;
   logic grant_dbg_s;
   logic wd_clear_s;
   logic wd_enable_s;
   logic wd_expired_s;

   // The cpu is locked out of new grants while the debugger holds it.
   assign cpu_elig_s = op_active(cpu_op) && !dbg_hold;
   assign dbg_elig_s = op_active(dbg_op);

   mem_arb_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clock   (clock),
      .reset   (reset),
      .clear   (wd_clear_s),
      .enable  (wd_enable_s),
      .expired (wd_expired_s)
   );

   // State and output registers; reset drops the port to NOP immediately.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r       <= ARB_IDLE;
         mem_op_r      <= MEM_NOP;
         mem_addr_r    <= {ADDR_WIDTH{1'b0}};
         mem_wdata_r   <= {DATA_BUS_WIDTH{1'b0}};
         cpu_rdata_r   <= {DATA_BUS_WIDTH{1'b0}};
         dbg_rdata_r   <= {DATA_BUS_WIDTH{1'b0}};
         cpu_done_r    <= 1'b0;
         dbg_done_r    <= 1'b0;
         owner_r       <= OWN_CPU;
         last_grant_r  <= OWN_DBG;
         timeout_err_r <= 1'b0;
      end else begin
         state_r       <= state_s;
         mem_op_r      <= mem_op_s;
         mem_addr_r    <= mem_addr_s;
         mem_wdata_r   <= mem_wdata_s;
         cpu_rdata_r   <= cpu_rdata_s;
         dbg_rdata_r   <= dbg_rdata_s;
         cpu_done_r    <= cpu_done_s;
         dbg_done_r    <= dbg_done_s;
         owner_r       <= owner_s;
         last_grant_r  <= last_grant_s;
         timeout_err_r <= timeout_err_s;
      end
   end

   // Next-state and next-output logic: grant, track the transfer, release.
   always_comb begin
      state_s       = state_r;
      mem_op_s      = mem_op_r;
      mem_addr_s    = mem_addr_r;
      mem_wdata_s   = mem_wdata_r;
      cpu_rdata_s   = cpu_rdata_r;
      dbg_rdata_s   = dbg_rdata_r;
      cpu_done_s    = 1'b0;
      dbg_done_s    = 1'b0;
      owner_s       = owner_r;
      last_grant_s  = last_grant_r;
      timeout_err_s = timeout_err_r;
      grant_dbg_s   = 1'b0;
      wd_clear_s    = 1'b0;
      wd_enable_s   = 1'b0;

      case (state_r)
         ARB_IDLE: begin
            mem_op_s = MEM_NOP;
            if (cpu_elig_s || dbg_elig_s) begin
               // On a tie, the side that did not win last time goes next.
               if (cpu_elig_s && dbg_elig_s) begin
                  grant_dbg_s = (last_grant_r == OWN_CPU);
               end else begin
                  grant_dbg_s = dbg_elig_s;
               end
               if (grant_dbg_s) begin
                  mem_op_s     = dbg_op;
                  mem_addr_s   = dbg_addr;
                  mem_wdata_s  = dbg_wdata;
                  owner_s      = OWN_DBG;
                  last_grant_s = OWN_DBG;
               end else begin
                  mem_op_s     = cpu_op;
                  mem_addr_s   = cpu_addr;
                  mem_wdata_s  = cpu_wdata;
                  owner_s      = OWN_CPU;
                  last_grant_s = OWN_CPU;
               end
               wd_clear_s = 1'b1;
               state_s    = ARB_BUSY;
            end else begin
               state_s = ARB_IDLE;
            end
         end

         ARB_BUSY: begin
            wd_enable_s = 1'b1;
            // mem_done is checked first so a completion on the limit cycle still counts.
            if (mem_done) begin
               if (mem_op_r == MEM_READ) begin
                  if (owner_r == OWN_DBG) begin
                     dbg_rdata_s = mem_rdata;
                  end else begin
                     cpu_rdata_s = mem_rdata;
                  end
               end else begin
                  cpu_rdata_s = cpu_rdata_r;
               end
               if (owner_r == OWN_DBG) begin
                  dbg_done_s = 1'b1;
               end else begin
                  cpu_done_s = 1'b1;
               end
               mem_op_s = MEM_NOP;
               state_s  = ARB_RELEASE;
            end else if (wd_expired_s) begin
               if (owner_r == OWN_DBG) begin
                  dbg_done_s = 1'b1;
               end else begin
                  cpu_done_s = 1'b1;
               end
               timeout_err_s = 1'b1;
               mem_op_s      = MEM_NOP;
               state_s       = ARB_RELEASE;
            end else begin
               state_s = ARB_BUSY;
            end
         end

         ARB_RELEASE: begin
            mem_op_s = MEM_NOP;
            state_s  = ARB_IDLE;
         end

         default: begin
            mem_op_s = MEM_NOP;
            state_s  = ARB_IDLE;
         end
      endcase
   end

   assign mem_op      = mem_op_r;
   assign mem_addr    = mem_addr_r;
   assign mem_wdata   = mem_wdata_r;
   assign cpu_rdata   = cpu_rdata_r;
   assign dbg_rdata   = dbg_rdata_r;
   assign cpu_done    = cpu_done_r;
   assign dbg_done    = dbg_done_r;
   assign owner_dbg   = (owner_r == OWN_DBG);
   assign timeout_err = timeout_err_r;

endmodule
